// File: rtl/epl_row_access_ctrl_if.sv
// Request/row-control bundle between a requester and epl_row_access_ctrl.
// Master drives the request side; slave drives row controls and status.
`ifndef ADDR_AXO
`define ADDR_AXO 8
`endif

interface epl_row_access_ctrl_if #(
    parameter int ADDR_W = `ADDR_AXO
) ();
    logic              pReq_i;
    logic              pWe_i;
    logic [ADDR_W-1:0] pAddr_i;
    logic              pReady_o;
    logic              pAck_o;
    logic              pSae_o;
    logic              pValide_o;
    logic              pRead_o;
    logic [ADDR_W-1:0] pArx_o;

    modport master (
        output pReq_i, pWe_i, pAddr_i,
        input  pReady_o, pAck_o, pSae_o, pValide_o, pRead_o, pArx_o
    );

    modport slave (
        input  pReq_i, pWe_i, pAddr_i,
        output pReady_o, pAck_o, pSae_o, pValide_o, pRead_o, pArx_o
    );
endinterface

// File: rtl/epl_row_access_ctrl.sv
// Row access sequencer: read -> restore -> precharge, write -> precharge.
// All outputs are registered; reset drops row controls asynchronously.
`ifndef ADDR_AXO
`define ADDR_AXO 8
`endif

module epl_row_access_ctrl #(
    parameter int ADDR_W = `ADDR_AXO,
    parameter int T_RD   = 2,
    parameter int T_WR   = 3,
    parameter int T_PRE  = 1
) (
    input  logic                  pClk_i,
    input  logic                  nRst_i,
    epl_row_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_RESTORE = 3'd2,
        S_WRITE   = 3'd3,
        S_PRECH   = 3'd4
    } state_t;

    localparam logic [7:0] RD_LAST  = 8'(T_RD - 1);
    localparam logic [7:0] WR_LAST  = 8'(T_WR - 1);
    localparam logic [7:0] PRE_LAST = 8'(T_PRE - 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] arx_q;
    logic              ready_q;
    logic              ack_q;
    logic              sae_q;
    logic              valide_q;
    logic              read_q;
    logic              accept;

    assign accept = bus.pReq_i & ready_q;

    // Sequencer: state, phase counter and registered row controls.
    always_ff @(posedge pClk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            arx_q    <= '0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            sae_q    <= 1'b0;
            valide_q <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            sae_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        arx_q   <= bus.pAddr_i;
                        cnt_q   <= 8'd0;
                        ready_q <= 1'b0;
                        if (bus.pWe_i) begin
                            state_q  <= S_WRITE;
                            valide_q <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            read_q  <= 1'b1;
                            sae_q   <= (RD_LAST == 8'd0);
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q == RD_LAST) begin
                        state_q  <= S_RESTORE;
                        cnt_q    <= 8'd0;
                        read_q   <= 1'b0;
                        valide_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        sae_q <= ((cnt_q + 8'd1) == RD_LAST);
                    end
                end
                S_RESTORE, S_WRITE: begin
                    if (cnt_q == WR_LAST) begin
                        state_q  <= S_PRECH;
                        cnt_q    <= 8'd0;
                        valide_q <= 1'b0;
                        ack_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_PRECH: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 8'd0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= 8'd0;
                    ready_q  <= 1'b1;
                    valide_q <= 1'b0;
                    read_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pReady_o  = ready_q;
    assign bus.pAck_o    = ack_q;
    assign bus.pSae_o    = sae_q;
    assign bus.pValide_o = valide_q;
    assign bus.pRead_o   = read_q;
    assign bus.pArx_o    = arx_q;

endmodule

// File: tb/tb_epl_row_access_ctrl.sv
// Testbench for epl_row_access_ctrl: default timing DUT plus an
// all-ones timing DUT, checked cycle by cycle against a scoreboard.
module tb_epl_row_access_ctrl;

    localparam int AW = 8;

    logic clk;
    logic rst_n;

    // {ready, ack, sae, valide, read, arx}
    typedef logic [AW+4:0] vec_t;

    vec_t q[$];
    vec_t exp_v;
    vec_t got_v;
    int   n_chk;
    int   n_fail;

    epl_row_access_ctrl_if #(.ADDR_W(AW)) if0 ();
    epl_row_access_ctrl_if #(.ADDR_W(AW)) if1 ();

    epl_row_access_ctrl #(
        .ADDR_W(AW), .T_RD(2), .T_WR(3), .T_PRE(1)
    ) dut (
        .pClk_i (clk),
        .nRst_i (rst_n),
        .bus    (if0.slave)
    );

    epl_row_access_ctrl #(
        .ADDR_W(AW), .T_RD(1), .T_WR(1), .T_PRE(1)
    ) dut1 (
        .pClk_i (clk),
        .nRst_i (rst_n),
        .bus    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t obs0();
        return {if0.pReady_o, if0.pAck_o, if0.pSae_o,
                if0.pValide_o, if0.pRead_o, if0.pArx_o};
    endfunction

    function automatic vec_t obs1();
        return {if1.pReady_o, if1.pAck_o, if1.pSae_o,
                if1.pValide_o, if1.pRead_o, if1.pArx_o};
    endfunction

    // Reference model: expected per-cycle outputs after an accept edge.
    task automatic model_op(input logic we, input logic [AW-1:0] a,
                            input int trd, input int twr, input int tpre);
        if (!we) begin
            for (int i = 0; i < trd; i++)
                q.push_back({1'b0, 1'b0, 1'(i == trd - 1), 1'b0, 1'b1, a});
        end
        for (int i = 0; i < twr; i++)
            q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a});
        for (int i = 0; i < tpre; i++)
            q.push_back({1'b0, 1'(i == 0), 1'b0, 1'b0, 1'b0, a});
    endtask

    task automatic model_idle(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++)
            q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        exp_v = {1'b1, 4'b0000, 8'h00};
        got_v = obs0();
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h expected %h", got_v, exp_v);
        end
        got_v = obs1();
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h expected %h", got_v, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got_v = obs0();
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL idle_dut0: got %h expected %h", got_v, exp_v);
        end
        got_v = obs1();
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL idle_dut1: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_write();
        q.delete();
        @(negedge clk);
        if0.pReq_i  = 1'b1;
        if0.pWe_i   = 1'b1;
        if0.pAddr_i = 8'h5A;
        model_op(1'b1, 8'h5A, 2, 3, 1);
        model_idle(8'h5A, 1);
        @(posedge clk);
        while (q.size() > 0) begin
            @(negedge clk);
            exp_v = q.pop_front();
            got_v = obs0();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL write: got %h expected %h", got_v, exp_v);
            end
            if0.pReq_i  = 1'b0;
            if0.pWe_i   = 1'b0;
            if0.pAddr_i = 8'hFF;
        end
    endtask

    task automatic test_read();
        q.delete();
        @(negedge clk);
        if0.pReq_i  = 1'b1;
        if0.pWe_i   = 1'b0;
        if0.pAddr_i = 8'h03;
        model_op(1'b0, 8'h03, 2, 3, 1);
        model_idle(8'h03, 1);
        @(posedge clk);
        while (q.size() > 0) begin
            @(negedge clk);
            exp_v = q.pop_front();
            got_v = obs0();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL read: got %h expected %h", got_v, exp_v);
            end
            if0.pReq_i  = 1'b0;
            if0.pWe_i   = 1'b1;
            if0.pAddr_i = 8'hC3;
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        q.delete();
        @(negedge clk);
        if0.pReq_i  = 1'b1;
        if0.pWe_i   = 1'b0;
        if0.pAddr_i = 8'h03;
        model_op(1'b0, 8'h03, 2, 3, 1);
        model_idle(8'h03, 1);
        model_op(1'b0, 8'h11, 2, 3, 1);
        model_idle(8'h11, 1);
        @(posedge clk);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            k++;
            exp_v = q.pop_front();
            got_v = obs0();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL busy_ignore c%0d: got %h expected %h",
                         k, got_v, exp_v);
            end
            if0.pAddr_i = 8'h11;
            if (k == 8) if0.pReq_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        @(negedge clk);
        if0.pReq_i  = 1'b1;
        if0.pWe_i   = 1'b0;
        if0.pAddr_i = 8'h03;
        q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03});
        q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03});
        q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03});
        @(posedge clk);
        while (q.size() > 0) begin
            @(negedge clk);
            exp_v = q.pop_front();
            got_v = obs0();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_pre: got %h expected %h",
                         got_v, exp_v);
            end
            if0.pReq_i = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {1'b1, 4'b0000, 8'h00};
        got_v = obs0();
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h",
                     got_v, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_idle(8'h00, 3);
        while (q.size() > 0) begin
            @(negedge clk);
            exp_v = q.pop_front();
            got_v = obs0();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_post: got %h expected %h",
                         got_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        q.delete();
        @(negedge clk);
        if1.pReq_i  = 1'b1;
        if1.pWe_i   = 1'b0;
        if1.pAddr_i = 8'h21;
        model_op(1'b0, 8'h21, 1, 1, 1);
        model_idle(8'h21, 1);
        model_op(1'b0, 8'h22, 1, 1, 1);
        model_idle(8'h22, 2);
        @(posedge clk);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            k++;
            exp_v = q.pop_front();
            got_v = obs1();
            n_chk++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %h expected %h",
                         k, got_v, exp_v);
            end
            n_chk++;
            if ((if1.pValide_o & if1.pRead_o) !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_excl c%0d: got %b expected 0",
                         k, if1.pValide_o & if1.pRead_o);
            end
            if (k == 4) if1.pAddr_i = 8'h22;
            if (k == 7) if1.pReq_i = 1'b0;
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        if0.pReq_i  = 1'b0;
        if0.pWe_i   = 1'b0;
        if0.pAddr_i = '0;
        if1.pReq_i  = 1'b0;
        if1.pWe_i   = 1'b0;
        if1.pAddr_i = '0;
        rst_n       = 1'b1;
        #1;
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
